lockstep_run_ctrl: RTL and testbench
====================================

Name: lockstep_run_ctrl

Overview:
- Sequencer for the dual-core lockstep pair.
- Holds both cores in reset, releases them, starts core0, then starts core1 a fixed skew later.
- Watches the lockstep checker's mismatch flag and both done flags, plus a watchdog timeout.
- On error it re-runs the program up to MAX_RETRY times, then latches a fault. It replaces the ad-hoc start-delay logic at the top of the dual-core wrapper.

Parameters:
- DELAY_CYCLES, 5, cycles core0 runs alone before start_core1 asserts (≥1)
- HOLD_CYCLES, 4, cycles core_rst_n is held low per (re)run (≥1)
- MAX_RETRY, 2, re-runs permitted after a failed run before FAULT
- TIMEOUT_CYCLES, 1000, max cycles in RUN_BOTH before the run counts as failed
- CNT_W, 10, phase counter width; must hold max(DELAY,HOLD,TIMEOUT)-1
- RC_W, 2, retry counter width; must hold MAX_RETRY

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; sampled only in IDLE
- clear  in  1  abort or acknowledge; returns to IDLE from any state
- mismatch  in  1  lockstep checker error flag
- done  in  2  core done flags, [0]=core0, [1]=core1
- core_rst_n  out  1  active-low reset to both cores
- start_core0  out  1  start to core0
- start_core1  out  1  start to core1
- busy  out  1  high in RESET_CORES, RUN0, RUN_BOTH
- pass  out  1  run completed cleanly
- fault  out  1  retries exhausted
- last_cause  out  1  cause of most recent failed run: 0=mismatch, 1=timeout
- retry_count  out  RC_W  failed runs so far in this job
- state  out  3  current state encoding (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. On rst=1 at a clk edge the state becomes IDLE and all counters, the done0 sticky flag, last_cause and retry_count become 0. This applies mid-run too; no partial-run state survives.
- Output style: Moore. Outputs decode from the state register, so each output changes in the same cycle the state changes.
- Per-state outputs:
  - IDLE: core_rst_n=1, all others 0.
  - RESET_CORES: core_rst_n=0, busy=1.
  - RUN0: start_core0=1, busy=1.
  - RUN_BOTH: start_core0=start_core1=1, busy=1.
  - PASS: pass=1.
  - FAULT: fault=1.
  - core_rst_n=1 in every state except RESET_CORES.
- Encoding: IDLE=0, RESET_CORES=1, RUN0=2, RUN_BOTH=3, PASS=4, FAULT=5. Codes 6 and 7 go to IDLE.
- clear=1 has highest priority after rst: next state is IDLE and retry_count is cleared.
- IDLE: start=1 → RESET_CORES; phase counter=0, retry_count=0.
- RESET_CORES: counter increments. At count HOLD_CYCLES-1 → RUN0 with counter=0 and done0 sticky cleared. core_rst_n is therefore low for exactly HOLD_CYCLES cycles.
- RUN0: counter increments. At count DELAY_CYCLES-1 → RUN_BOTH with counter=0. The rising edge of start_core1 follows the rising edge of start_core0 by exactly DELAY_CYCLES cycles. mismatch is ignored in RUN0 (core1 not yet running).
- done0 sticky: set when done[0]=1 in RUN0 or RUN_BOTH.
- RUN_BOTH exits, in priority order:
  1. mismatch=1: failed run, cause 0.
  2. Counter reaches TIMEOUT_CYCLES-1: failed run, cause 1.
  3. (done0 sticky or done[0]) and done[1]: → PASS.
  - mismatch beats completion in the same cycle; mismatch beats timeout.
- Failed run handling: last_cause is updated.
  - If retry_count==MAX_RETRY → FAULT, with retry_count unchanged.
  - Otherwise retry_count+1 and → RESET_CORES with counter=0.
- PASS and FAULT are held until clear. start is ignored in them.
- Counter arithmetic is unsigned CNT_W bits and never wraps: every phase exits on terminal count. done inputs are ignored outside RUN0/RUN_BOTH.

Decomposition:
- Shared package lockstep_pkg holds:
  - state encoding constants
  - cause codes CAUSE_MISMATCH=0 and CAUSE_TIMEOUT=1
  - default DELAY_CYCLES and HOLD_CYCLES, reused by the checker skew logic
- One sub-module, ls_phase_counter: a CNT_W counter with sync clear, enable, and a terminal-match output against a supplied limit. One instance is shared across the hold, delay and timeout phases, since those phases are mutually exclusive.

Test Plan (defaults, MAX_RETRY=2, TIMEOUT_CYCLES=64):
- Clean run: rst, then start=1 at cycle 0.
  - core_rst_n low cycles 1–4; start_core0 rises at cycle 5; start_core1 rises at cycle 10.
  - done[0] pulse at 40 and done[1]=1 at 45 → pass=1 from cycle 46; retry_count=0.
- Single mismatch: mismatch=1 for 1 cycle at RUN_BOTH cycle 3.
  - Next cycle state=RESET_CORES, retry_count=1, last_cause=0.
  - Second run is clean → pass=1.
- Retries exhausted: mismatch is forced in each of 3 runs → fault=1, retry_count=2, state=5, held until clear.
  - clear=1 → IDLE next cycle, retry_count=0.
- Timeout: done never asserts → after 64 RUN_BOTH cycles, retry with last_cause=1.
  - Third timeout → fault=1.
- Simultaneous events: mismatch=1 in the same cycle done[1]=1 with done0 sticky set → failed run, not PASS. mismatch asserted during RUN0 → ignored.
- Reset and abort mid-run: rst=1 in RUN_BOTH → next cycle state=IDLE, all outputs at IDLE values, retry_count=0.
  - clear=1 during RESET_CORES gives the same result.
  - start held high through PASS does not restart.

Source files
------------

// File: rtl/lockstep_pkg.sv
// Shared definitions for the dual-core lockstep run sequencer and the checker skew logic.
package lockstep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_RESET_CORES = 3'd1,
      ST_RUN0        = 3'd2,
      ST_RUN_BOTH    = 3'd3,
      ST_PASS        = 3'd4,
      ST_FAULT       = 3'd5
   } ls_state_t;

   localparam logic CAUSE_MISMATCH = 1'b0;
   localparam logic CAUSE_TIMEOUT  = 1'b1;

   localparam int DEF_DELAY_CYCLES = 5;
   localparam int DEF_HOLD_CYCLES  = 4;

endpackage

// File: rtl/ls_phase_counter.sv
// Phase counter shared by the hold, skew and watchdog phases; tc flags count == limit.
module ls_phase_counter #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign tc = (cnt_q == limit);

endmodule

// File: rtl/lockstep_run_ctrl.sv
// Run sequencer for the lockstep core pair: reset hold, staggered start, supervised run, retry/fault.
//
// state       | meaning
// IDLE        | waiting for start, cores out of reset and not started
// RESET_CORES | holding both cores in reset for HOLD_CYCLES
// RUN0        | core0 running alone for DELAY_CYCLES
// RUN_BOTH    | both cores running, watching mismatch/done/watchdog
// PASS        | run completed cleanly, held until clear
// FAULT       | retries exhausted, held until clear
module lockstep_run_ctrl
   import lockstep_pkg::*;
#(
   parameter int DELAY_CYCLES   = DEF_DELAY_CYCLES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int MAX_RETRY      = 2,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 10,
   parameter int RC_W           = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            clear,
   input  logic            mismatch,
   input  logic [1:0]      done,
   output logic            core_rst_n,
   output logic            start_core0,
   output logic            start_core1,
   output logic            busy,
   output logic            pass,
   output logic            fault,
   output logic            last_cause,
   output logic [RC_W-1:0] retry_count,
   output logic [2:0]      state
);

   localparam logic [CNT_W-1:0] HOLD_LIM    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LIM   = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRY);

   ls_state_t        state_q, state_d;
   logic [CNT_W-1:0] limit;
   logic             cnt_en, cnt_clr, cnt_tc;
   logic             done0_q;
   logic [RC_W-1:0]  retry_q;
   logic             cause_q;
   logic             fail_run, fail_cause;

   // Any state change restarts the phase count, so each phase begins at zero.
   assign cnt_clr = (state_d != state_q);

   ls_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (limit),
      .tc    (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      limit      = '0;
      cnt_en     = 1'b0;
      fail_run   = 1'b0;
      fail_cause = CAUSE_MISMATCH;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_RESET_CORES;
            end
            ST_RESET_CORES: begin
               cnt_en = 1'b1;
               limit  = HOLD_LIM;
               if (cnt_tc) state_d = ST_RUN0;
            end
            ST_RUN0: begin
               cnt_en = 1'b1;
               limit  = DELAY_LIM;
               if (cnt_tc) state_d = ST_RUN_BOTH;
            end
            ST_RUN_BOTH: begin
               cnt_en = 1'b1;
               limit  = TIMEOUT_LIM;
               if (mismatch) begin
                  fail_run = 1'b1;
               end else if (cnt_tc) begin
                  fail_run   = 1'b1;
                  fail_cause = CAUSE_TIMEOUT;
               end else if ((done0_q || done[0]) && done[1]) begin
                  state_d = ST_PASS;
               end
               if (fail_run) begin
                  state_d = (retry_q == RETRY_MAX) ? ST_FAULT : ST_RESET_CORES;
               end
            end
            ST_PASS:  state_d = ST_PASS;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done0_q <= 1'b0;
         retry_q <= '0;
         cause_q <= CAUSE_MISMATCH;
      end else begin
         if (state_q == ST_RESET_CORES && state_d == ST_RUN0) begin
            done0_q <= 1'b0;
         end else if ((state_q == ST_RUN0 || state_q == ST_RUN_BOTH) && done[0]) begin
            done0_q <= 1'b1;
         end
         if (clear || (state_q == ST_IDLE && start)) begin
            retry_q <= '0;
         end else if (fail_run && retry_q != RETRY_MAX) begin
            retry_q <= retry_q + RC_W'(1);
         end
         if (fail_run) cause_q <= fail_cause;
      end
   end

   always_comb begin
      core_rst_n  = 1'b1;
      start_core0 = 1'b0;
      start_core1 = 1'b0;
      busy        = 1'b0;
      pass        = 1'b0;
      fault       = 1'b0;
      case (state_q)
         ST_RESET_CORES: begin
            core_rst_n = 1'b0;
            busy       = 1'b1;
         end
         ST_RUN0: begin
            start_core0 = 1'b1;
            busy        = 1'b1;
         end
         ST_RUN_BOTH: begin
            start_core0 = 1'b1;
            start_core1 = 1'b1;
            busy        = 1'b1;
         end
         ST_PASS:  pass  = 1'b1;
         ST_FAULT: fault = 1'b1;
         default:  ;
      endcase
   end

   assign state       = state_q;
   assign retry_count = retry_q;
   assign last_cause  = cause_q;

endmodule

// File: tb/tb_lockstep_run_ctrl.sv
// Scenario bench for lockstep_run_ctrl: expected per-cycle outputs are queued up front and compared as cycles elapse.
module tb_lockstep_run_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_RUN0 = 3'd2,
                          S_RB = 3'd3, S_PASS = 3'd4, S_FAULT = 3'd5;

   logic       clk = 1'b0;
   logic       rst = 1'b0, start = 1'b0, clear = 1'b0, mismatch = 1'b0;
   logic [1:0] done_i = 2'b00;
   logic       core_rst_n, start_core0, start_core1, busy, pass, fault, last_cause;
   logic [1:0] retry_count;
   logic [2:0] state;
   logic [11:0] obs;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      string      name;
      logic [2:0] st;
      logic       lc;
      logic [1:0] rc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   lockstep_run_ctrl #(
      .DELAY_CYCLES(5), .HOLD_CYCLES(4), .MAX_RETRY(2),
      .TIMEOUT_CYCLES(64), .CNT_W(10), .RC_W(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .mismatch(mismatch),
      .done(done_i), .core_rst_n(core_rst_n), .start_core0(start_core0),
      .start_core1(start_core1), .busy(busy), .pass(pass), .fault(fault),
      .last_cause(last_cause), .retry_count(retry_count), .state(state)
   );

   assign obs = {core_rst_n, start_core0, start_core1, busy, pass, fault,
                 last_cause, retry_count, state};

   // {core_rst_n, start_core0, start_core1, busy, pass, fault} per state
   function automatic logic [11:0] model_out(logic [2:0] st, logic lc, logic [1:0] rc);
      logic [5:0] f;
      case (st)
         S_IDLE:  f = 6'b100000;
         S_RST:   f = 6'b000100;
         S_RUN0:  f = 6'b110100;
         S_RB:    f = 6'b111100;
         S_PASS:  f = 6'b100010;
         S_FAULT: f = 6'b100001;
         default: f = 6'b100000;
      endcase
      return {f, lc, rc, st};
   endfunction

   function automatic void expect_at(int c, string n, logic [2:0] st, logic lc, logic [1:0] rc);
      exp_t e;
      e.cyc = c; e.name = n; e.st = st; e.lc = lc; e.rc = rc;
      sb.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; clear = 1'b0; mismatch = 1'b0; done_i = 2'b00;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      expect_at(1, "reset_idle_a", S_IDLE, 1'b0, 2'd0);
      expect_at(2, "reset_idle_b", S_IDLE, 1'b0, 2'd0);
      expect_at(3, "reset_idle_c", S_IDLE, 1'b0, 2'd0);
      expect_at(4, "reset_release_start", S_RST, 1'b0, 2'd0);
      for (int c = 0; c <= 4; c++) begin
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (obs !== model_out(e.st, e.lc, e.rc)) begin
               failures++;
               $display("FAIL %s cycle=%0d got=%03h expected=%03h", e.name, c, obs, model_out(e.st, e.lc, e.rc));
            end
         end
         rst = (c < 3); start = 1'b1;
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL reset_leftover got=%0d pending expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_clean_run();
      exp_t e;
      do_reset();
      expect_at(0,  "clean_idle",       S_IDLE, 1'b0, 2'd0);
      expect_at(1,  "clean_hold_first", S_RST,  1'b0, 2'd0);
      expect_at(4,  "clean_hold_last",  S_RST,  1'b0, 2'd0);
      expect_at(5,  "clean_core0_rise", S_RUN0, 1'b0, 2'd0);
      expect_at(9,  "clean_core0_only", S_RUN0, 1'b0, 2'd0);
      expect_at(10, "clean_core1_rise", S_RB,   1'b0, 2'd0);
      expect_at(45, "clean_before_pass", S_RB,  1'b0, 2'd0);
      expect_at(46, "clean_pass",       S_PASS, 1'b0, 2'd0);
      expect_at(50, "clean_pass_held",  S_PASS, 1'b0, 2'd0);
      for (int c = 0; c <= 50; c++) begin
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (obs !== model_out(e.st, e.lc, e.rc)) begin
               failures++;
               $display("FAIL %s cycle=%0d got=%03h expected=%03h", e.name, c, obs, model_out(e.st, e.lc, e.rc));
            end
         end
         start = (c == 0);
         done_i = {(c >= 45), (c == 40)};
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL clean_leftover got=%0d pending expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_single_mismatch();
      exp_t e;
      do_reset();
      expect_at(13, "mm1_in_run",     S_RB,   1'b0, 2'd0);
      expect_at(14, "mm1_retry",      S_RST,  1'b0, 2'd1);
      expect_at(22, "mm1_run0_again", S_RUN0, 1'b0, 2'd1);
      expect_at(23, "mm1_rb_again",   S_RB,   1'b0, 2'd1);
      expect_at(31, "mm1_pass",       S_PASS, 1'b0, 2'd1);
      for (int c = 0; c <= 33; c++) begin
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (obs !== model_out(e.st, e.lc, e.rc)) begin
               failures++;
               $display("FAIL %s cycle=%0d got=%03h expected=%03h", e.name, c, obs, model_out(e.st, e.lc, e.rc));
            end
         end
         start = (c == 0);
         mismatch = (c == 13);
         done_i = (c == 30) ? 2'b11 : 2'b00;
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL mm1_leftover got=%0d pending expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_retry_exhaust();
      exp_t e;
      do_reset();
      expect_at(10, "exh_rb1",        S_RB,    1'b0, 2'd0);
      expect_at(11, "exh_retry1",     S_RST,   1'b0, 2'd1);
      expect_at(21, "exh_retry2",     S_RST,   1'b0, 2'd2);
      expect_at(30, "exh_rb3",        S_RB,    1'b0, 2'd2);
      expect_at(31, "exh_fault",      S_FAULT, 1'b0, 2'd2);
      expect_at(41, "exh_fault_held", S_FAULT, 1'b0, 2'd2);
      expect_at(42, "exh_clear_idle", S_IDLE,  1'b0, 2'd0);
      for (int c = 0; c <= 43; c++) begin
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (obs !== model_out(e.st, e.lc, e.rc)) begin
               failures++;
               $display("FAIL %s cycle=%0d got=%03h expected=%03h", e.name, c, obs, model_out(e.st, e.lc, e.rc));
            end
         end
         start = (c == 0);
         mismatch = (c == 10 || c == 20 || c == 30);
         clear = (c == 41);
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL exh_leftover got=%0d pending expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      do_reset();
      expect_at(73,  "to_last_rb1",  S_RB,    1'b0, 2'd0);
      expect_at(74,  "to_retry1",    S_RST,   1'b1, 2'd1);
      expect_at(146, "to_last_rb2",  S_RB,    1'b1, 2'd1);
      expect_at(147, "to_retry2",    S_RST,   1'b1, 2'd2);
      expect_at(219, "to_last_rb3",  S_RB,    1'b1, 2'd2);
      expect_at(220, "to_fault",     S_FAULT, 1'b1, 2'd2);
      for (int c = 0; c <= 222; c++) begin
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (obs !== model_out(e.st, e.lc, e.rc)) begin
               failures++;
               $display("FAIL %s cycle=%0d got=%03h expected=%03h", e.name, c, obs, model_out(e.st, e.lc, e.rc));
            end
         end
         start = (c == 0);
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL to_leftover got=%0d pending expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      do_reset();
      expect_at(9,  "sim_run0_ignores_mm", S_RUN0, 1'b0, 2'd0);
      expect_at(10, "sim_rb",              S_RB,   1'b0, 2'd0);
      expect_at(20, "sim_rb_before",       S_RB,   1'b0, 2'd0);
      expect_at(21, "sim_mm_beats_done",   S_RST,  1'b0, 2'd1);
      expect_at(36, "sim_sticky_cleared",  S_RB,   1'b0, 2'd1);
      expect_at(39, "sim_done0_alone",     S_RB,   1'b0, 2'd1);
      expect_at(41, "sim_sticky_pass",     S_PASS, 1'b0, 2'd1);
      for (int c = 0; c <= 42; c++) begin
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (obs !== model_out(e.st, e.lc, e.rc)) begin
               failures++;
               $display("FAIL %s cycle=%0d got=%03h expected=%03h", e.name, c, obs, model_out(e.st, e.lc, e.rc));
            end
         end
         start = (c == 0);
         mismatch = (c == 7 || c == 8 || c == 20);
         done_i = (c == 12 || c == 38) ? 2'b01 :
                  (c == 20 || c == 35 || c == 40) ? 2'b10 : 2'b00;
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sim_leftover got=%0d pending expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_abort();
      exp_t e;
      do_reset();
      expect_at(12, "ab_retry",          S_RST,  1'b0, 2'd1);
      expect_at(23, "ab_rb_before_rst",  S_RB,   1'b0, 2'd1);
      expect_at(24, "ab_rst_idle",       S_IDLE, 1'b0, 2'd0);
      expect_at(25, "ab_rst_stays_idle", S_IDLE, 1'b0, 2'd0);
      expect_at(41, "ab_retry2",         S_RST,  1'b0, 2'd1);
      expect_at(43, "ab_clear_idle",     S_IDLE, 1'b0, 2'd0);
      expect_at(45, "ab_clear_stays",    S_IDLE, 1'b0, 2'd0);
      expect_at(61, "ab_pass",           S_PASS, 1'b0, 2'd0);
      expect_at(70, "ab_start_no_rerun", S_PASS, 1'b0, 2'd0);
      for (int c = 0; c <= 70; c++) begin
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (obs !== model_out(e.st, e.lc, e.rc)) begin
               failures++;
               $display("FAIL %s cycle=%0d got=%03h expected=%03h", e.name, c, obs, model_out(e.st, e.lc, e.rc));
            end
         end
         start = (c == 0 || c == 30 || c >= 50);
         mismatch = (c == 11 || c == 40);
         rst = (c == 23);
         clear = (c == 42);
         done_i = (c == 60) ? 2'b11 : 2'b00;
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL ab_leftover got=%0d pending expected=0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_single_mismatch();
      test_retry_exhaust();
      test_timeout();
      test_simultaneous();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
